// File: rtl/invsqrt_pipeline.sv
// Pipelined fast inverse square root: magic-constant estimate plus Newton refinement.
// Defining INVSQRT_SECOND_ITER_EN adds a second Newton iteration (latency 9 instead of 5).
module invsqrt_pipeline (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic [31:0] fp_in,
   output logic [30:0] float_out,
   output logic        ready
);

`ifdef INVSQRT_SECOND_ITER_EN
   localparam int Iters = 2;
`else
   localparam int Iters = 1;
`endif
   localparam int Depth = 1 + 4 * Iters;

   localparam logic [31:0] Magic  = 32'h5F3759DF;
   localparam logic [31:0] PosInf = 32'h7F800000;
   localparam logic [31:0] QNan   = 32'h7FC00000;
   localparam logic [25:0] OneHalfFix = 26'h1800000;  // 1.5 with 24 fraction bits

   // Positive-operand multiply: 24x24 mantissa product, normalised, truncated,
   // zero/denormal inputs and underflow flushed to zero.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0]       ma;
      logic [47:0]       mb;
      logic [47:0]       prod;
      logic signed [9:0] ex;
      logic [22:0]       frac;
      ma   = {24'd0, 1'b1, a[22:0]};
      mb   = {24'd0, 1'b1, b[22:0]};
      prod = ma * mb;
      ex   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (prod[47]) begin
         frac = prod[46:24];
         ex   = ex + 10'sd1;
      end else begin
         frac = prod[45:23];
      end
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || ex <= 10'sd0) begin
         fmul = '0;
      end else if (ex >= 10'sd255) begin
         fmul = PosInf;
      end else begin
         fmul = {1'b0, ex[7:0], frac};
      end
   endfunction

   // 1.5 - t in fixed point aligned to 2^0; a non-positive difference flushes to zero.
   function automatic logic [31:0] sub_one_half(input logic [31:0] t);
      logic [25:0] tf;
      logic [25:0] diff;
      logic [25:0] norm;
      logic [7:0]  sh;
      logic [4:0]  lead;
      logic        big;
      sub_one_half = '0;
      tf   = '0;
      big  = 1'b0;
      lead = '0;
      sh   = 8'd127 - t[30:23];
      if (t[30:23] > 8'd127) begin
         big = 1'b1;
      end else if (t[30:23] != 8'd0 && sh <= 8'd25) begin
         tf = ({2'b00, 1'b1, t[22:0]} << 1) >> sh;
      end
      diff = OneHalfFix - tf;
      if (!big && tf < OneHalfFix) begin
         for (int i = 0; i < 26; i++) begin
            if (diff[i]) lead = i[4:0];
         end
         norm = diff << (5'd25 - lead);
         sub_one_half = {1'b0, 8'd103 + {3'b000, lead}, norm[24:2]};
      end
   endfunction

   // Stage 1: estimate, halved operand and special-case resolution.
   logic [31:0] y0_d, h_d, sp_d;
   logic        spf_d;

   always_comb begin
      y0_d  = '0;
      h_d   = '0;
      sp_d  = '0;
      spf_d = 1'b1;
      if (fp_in[30:23] == 8'd0) begin
         sp_d = PosInf;
      end else if (fp_in[30:23] == 8'hFF && fp_in[22:0] != 23'd0) begin
         sp_d = QNan;
      end else if (fp_in[31]) begin
         sp_d = QNan;
      end else if (fp_in[30:23] == 8'hFF) begin
         sp_d = '0;
      end else begin
         spf_d = 1'b0;
         y0_d  = Magic - {1'b0, fp_in[31:1]};
         h_d   = (fp_in[30:23] == 8'd1) ? '0 : {1'b0, fp_in[30:23] - 8'd1, fp_in[22:0]};
      end
   end

   logic [31:0]      y0_q, h_q;
   logic [31:0]      sp_q [Depth];
   logic [Depth-1:0] spf_q;
   logic [Depth-1:0] v_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         y0_q  <= '0;
         h_q   <= '0;
         spf_q <= '0;
         v_q   <= '0;
         for (int i = 0; i < Depth; i++) sp_q[i] <= '0;
      end else if (ce) begin
         y0_q     <= y0_d;
         h_q      <= h_d;
         sp_q[0]  <= sp_d;
         spf_q[0] <= spf_d;
         v_q[0]   <= 1'b1;
         for (int i = 1; i < Depth; i++) begin
            sp_q[i]  <= sp_q[i-1];
            spf_q[i] <= spf_q[i-1];
            v_q[i]   <= v_q[i-1];
         end
      end
   end

   logic [31:0] y_chain [Iters+1];
   logic [31:0] h_chain [Iters+1];

   assign y_chain[0] = y0_q;
   assign h_chain[0] = h_q;

   // Each iteration: y*y, h*(y*y), 1.5 - t, y*(1.5 - t); h travels alongside.
   for (genvar k = 0; k < Iters; k++) begin : g_iter
      logic [31:0] sq_q, y_a_q, h_a_q;
      logic [31:0] t_q, y_b_q, h_b_q;
      logic [31:0] s_q, y_c_q, h_c_q;
      logic [31:0] y_o_q, h_o_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            sq_q  <= '0;
            y_a_q <= '0;
            h_a_q <= '0;
            t_q   <= '0;
            y_b_q <= '0;
            h_b_q <= '0;
            s_q   <= '0;
            y_c_q <= '0;
            h_c_q <= '0;
            y_o_q <= '0;
            h_o_q <= '0;
         end else if (ce) begin
            sq_q  <= fmul(y_chain[k], y_chain[k]);
            y_a_q <= y_chain[k];
            h_a_q <= h_chain[k];
            t_q   <= fmul(h_a_q, sq_q);
            y_b_q <= y_a_q;
            h_b_q <= h_a_q;
            s_q   <= sub_one_half(t_q);
            y_c_q <= y_b_q;
            h_c_q <= h_b_q;
            y_o_q <= fmul(y_c_q, s_q);
            h_o_q <= h_c_q;
         end
      end

      assign y_chain[k+1] = y_o_q;
      assign h_chain[k+1] = h_o_q;
   end

   assign float_out = spf_q[Depth-1] ? sp_q[Depth-1][30:0] : y_chain[Iters][30:0];
   assign ready     = v_q[Depth-1];

endmodule

// File: tb/tb_invsqrt_pipeline.sv
// Randomised bench for invsqrt_pipeline against a real-arithmetic reference and an
// ideal L-deep delay line of captured operands.
module tb_invsqrt_pipeline;

`ifdef INVSQRT_SECOND_ITER_EN
   localparam int  L   = 9;
   localparam real Tol = 5.0e-6;
`else
   localparam int  L   = 5;
   localparam real Tol = 2.0e-3;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic [31:0] fp_in = '0;
   logic [30:0] float_out;
   logic        ready;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      bit          v;
      logic [31:0] op;
   } slot_t;

   slot_t pipe[$];

   invsqrt_pipeline dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .fp_in    (fp_in),
      .float_out(float_out),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   function automatic real f2r(input logic [31:0] b);
      real m;
      int  e;
      m = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      return m * (2.0 ** e);
   endfunction

   // {is_special, encoding} from the IEEE class of the operand
   function automatic logic [32:0] special_of(input logic [31:0] x);
      if (x[30:23] == 8'd0) return {1'b1, 32'h7F800000};
      if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return {1'b1, 32'h7FC00000};
      if (x[31]) return {1'b1, 32'h7FC00000};
      if (x[30:23] == 8'hFF) return {1'b1, 32'h00000000};
      return 33'd0;
   endfunction

   function automatic real rel_err(input logic [31:0] op, input logic [30:0] out);
      logic [32:0] sp;
      real         want;
      real         got;
      sp = special_of(op);
      if (sp[32]) return (out == sp[30:0]) ? 0.0 : 1.0e9;
      if (out[30:23] == 8'd0 || out[30:23] == 8'hFF) return 1.0e9;
      want = 1.0 / $sqrt(f2r(op));
      got  = f2r({1'b0, out});
      return ((got > want) ? got - want : want - got) / want;
   endfunction

   function automatic real ideal(input logic [31:0] op);
      if (special_of(op) != 33'd0) return -1.0;
      return 1.0 / $sqrt(f2r(op));
   endfunction

   // Extreme exponents lose intermediates to flush-to-zero, so random normals avoid them.
   function automatic logic [31:0] rand_norm();
      return {1'b0, 8'($urandom_range(250, 2)), 23'($urandom)};
   endfunction

   task automatic tick(input logic r, input logic c, input logic [31:0] d);
      rst   = r;
      ce    = c;
      fp_in = d;
      @(posedge clk);
      if (r) begin
         pipe.delete();
         repeat (L) pipe.push_back('{1'b0, 32'd0});
      end else if (c) begin
         pipe.push_back('{1'b1, d});
         void'(pipe.pop_front());
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, (i == 2), $urandom);
         n_cmp++;
         if (ready !== 1'b0 || float_out !== 31'd0) begin
            n_fail++;
            $display("FAIL reset[%0d]: got ready=%b out=%h, want ready=0 out=0", i, ready,
                     float_out);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] ops [3];
      ops[0] = 32'h40800000;
      ops[1] = 32'h3F800000;
      ops[2] = 32'h42C80000;
      for (int i = 0; i < 3 + L; i++) begin
         tick(1'b0, 1'b1, (i < 3) ? ops[i] : rand_norm());
         n_cmp++;
         if (ready !== pipe[0].v ||
             (pipe[0].v ? rel_err(pipe[0].op, float_out) > Tol : float_out !== 31'd0)) begin
            n_fail++;
            $display("FAIL directed[%0d]: got ready=%b out=%h, want ready=%b ~%g for op %h",
                     i, ready, float_out, pipe[0].v, ideal(pipe[0].op), pipe[0].op);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] ops [8];
      ops[0] = 32'h00000000;
      ops[1] = 32'hC0800000;
      ops[2] = 32'h7F800000;
      ops[3] = 32'h7FC00001;
      ops[4] = 32'h80000000;
      ops[5] = 32'h00000001;
      ops[6] = 32'hFF800000;
      ops[7] = 32'hBF800000;
      for (int i = 0; i < 8 + L; i++) begin
         tick(1'b0, 1'b1, (i < 8) ? ops[i] : rand_norm());
         n_cmp++;
         if (ready !== pipe[0].v ||
             (pipe[0].v ? rel_err(pipe[0].op, float_out) > Tol : float_out !== 31'd0)) begin
            n_fail++;
            $display("FAIL special[%0d]: got ready=%b out=%h, want ready=%b class of op %h",
                     i, ready, float_out, pipe[0].v, pipe[0].op);
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 10 + 5 + L; i++) begin
         if (i >= 10 && i < 15) tick(1'b0, 1'b0, rand_norm());
         else tick(1'b0, 1'b1, rand_norm());
         n_cmp++;
         if (ready !== pipe[0].v ||
             (pipe[0].v ? rel_err(pipe[0].op, float_out) > Tol : float_out !== 31'd0)) begin
            n_fail++;
            $display("FAIL stall[%0d]: got ready=%b out=%h, want ready=%b ~%g for op %h",
                     i, ready, float_out, pipe[0].v, ideal(pipe[0].op), pipe[0].op);
         end
      end
   endtask

   task automatic test_reset_midflight();
      tick(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, rand_norm());
      tick(1'b1, 1'b1, rand_norm());
      n_cmp++;
      if (ready !== 1'b0 || float_out !== 31'd0) begin
         n_fail++;
         $display("FAIL midflight_rst: got ready=%b out=%h, want ready=0 out=0", ready,
                  float_out);
      end
      for (int i = 0; i < 3 * L; i++) begin
         tick(1'b0, ($urandom_range(3, 0) != 0), rand_norm());
         n_cmp++;
         if (ready !== pipe[0].v ||
             (pipe[0].v ? rel_err(pipe[0].op, float_out) > Tol : float_out !== 31'd0)) begin
            n_fail++;
            $display("FAIL midflight[%0d]: got ready=%b out=%h, want ready=%b ~%g for op %h",
                     i, ready, float_out, pipe[0].v, ideal(pipe[0].op), pipe[0].op);
         end
      end
   endtask

   task automatic test_random_stream();
      logic [31:0] op;
      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(9, 0) == 0) ? $urandom : rand_norm();
         tick(1'b0, ($urandom_range(3, 0) != 0), op);
         n_cmp++;
         if (ready !== pipe[0].v ||
             (pipe[0].v ? rel_err(pipe[0].op, float_out) > Tol : float_out !== 31'd0)) begin
            n_fail++;
            $display("FAIL random[%0d]: got ready=%b out=%h, want ready=%b ~%g for op %h",
                     i, ready, float_out, pipe[0].v, ideal(pipe[0].op), pipe[0].op);
         end
      end
   endtask

   initial begin
      repeat (L) pipe.push_back('{1'b0, 32'd0});
      test_reset();
      test_directed();
      test_specials();
      test_stall();
      test_reset_midflight();
      test_random_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
